// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Holds the FSM state encoding and the register-index width.
package pipe_hazard_ctrl_pkg;

  localparam int REG_IDX_W = 4;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle between the hazard controller and the pipeline datapath.
// The master side is the controller; the slave side is the pipeline it steers.
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  import pipe_hazard_ctrl_pkg::*;

  logic [REG_IDX_W-1:0] id_src1;
  logic [REG_IDX_W-1:0] id_src2;
  logic                 id_use_src1;
  logic                 id_two_src;
  logic [REG_IDX_W-1:0] exe_dest;
  logic                 exe_wb_en;
  logic                 exe_mem_r_en;
  logic [REG_IDX_W-1:0] mem_dest;
  logic                 mem_wb_en;
  logic                 branch_taken;
  logic                 mem_req;
  logic                 mem_ready;
  logic                 cnt_clr;

  logic                 pc_ld;
  logic                 if_id_ld;
  logic                 if_id_flush;
  logic                 id_exe_ld;
  logic                 id_exe_flush;
  logic                 exe_mem_ld;
  logic                 mem_wb_ld;
  logic [CNT_W-1:0]     stall_cnt;
  logic [CNT_W-1:0]     flush_cnt;
  logic                 mem_timeout;

  modport master (
    input  id_src1, id_src2, id_use_src1, id_two_src,
    input  exe_dest, exe_wb_en, exe_mem_r_en,
    input  mem_dest, mem_wb_en,
    input  branch_taken, mem_req, mem_ready, cnt_clr,
    output pc_ld, if_id_ld, if_id_flush, id_exe_ld, id_exe_flush,
    output exe_mem_ld, mem_wb_ld,
    output stall_cnt, flush_cnt, mem_timeout
  );

  modport slave (
    output id_src1, id_src2, id_use_src1, id_two_src,
    output exe_dest, exe_wb_en, exe_mem_r_en,
    output mem_dest, mem_wb_en,
    output branch_taken, mem_req, mem_ready, cnt_clr,
    input  pc_ld, if_id_ld, if_id_flush, id_exe_ld, id_exe_flush,
    input  exe_mem_ld, mem_wb_ld,
    input  stall_cnt, flush_cnt, mem_timeout
  );

endinterface

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// RAW hazard detection between the ID instruction and older instructions.
// With forwarding only a load in EXE can cause a hazard; without it any writer in EXE or MEM does.
module hazard_detect
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int FWD_EN = 1
) (
  input  logic [REG_IDX_W-1:0] i_id_src1,
  input  logic [REG_IDX_W-1:0] i_id_src2,
  input  logic                 i_id_use_src1,
  input  logic                 i_id_two_src,
  input  logic [REG_IDX_W-1:0] i_exe_dest,
  input  logic                 i_exe_wb_en,
  input  logic                 i_exe_mem_r_en,
  input  logic [REG_IDX_W-1:0] i_mem_dest,
  input  logic                 i_mem_wb_en,
  output logic                 o_hz
);

  logic w_exe_hit;
  logic w_mem_hit;
  logic w_hz_fwd;
  logic w_hz_nofwd;

  assign w_exe_hit = (i_id_use_src1 && (i_id_src1 == i_exe_dest)) ||
                     (i_id_two_src  && (i_id_src2 == i_exe_dest));
  assign w_mem_hit = (i_id_use_src1 && (i_id_src1 == i_mem_dest)) ||
                     (i_id_two_src  && (i_id_src2 == i_mem_dest));

  assign w_hz_fwd   = i_exe_wb_en & i_exe_mem_r_en & w_exe_hit;
  assign w_hz_nofwd = (i_exe_wb_en & w_exe_hit) | (i_mem_wb_en & w_mem_hit);

  assign o_hz = (FWD_EN != 0) ? w_hz_fwd : w_hz_nofwd;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline load/flush controller: memory freeze, branch squash, load-use bubbles,
// plus saturating stall/flush counters and a sticky memory-timeout flag.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int FWD_EN  = 1,
  parameter int CNT_W   = 32,
  parameter int TMO_CYC = 255
) (
  input  logic                clk,
  input  logic                rst,
  pipe_hazard_ctrl_if.master  bus
);

  localparam int WAIT_W = $clog2(TMO_CYC + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TMO_CYC);
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

  state_t            r_state;
  state_t            w_state_nxt;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [WAIT_W-1:0] w_wait_nxt;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic [CNT_W-1:0]  r_flush_cnt;
  logic              r_mem_timeout;

  logic w_hz;
  logic w_hold;
  logic w_stall_inc;
  logic w_flush_inc;
  logic w_pc_ld;
  logic w_if_id_ld;
  logic w_if_id_flush;
  logic w_id_exe_ld;
  logic w_id_exe_flush;
  logic w_exe_mem_ld;
  logic w_mem_wb_ld;

  hazard_detect #(
    .FWD_EN (FWD_EN)
  ) u_hazard_detect (
    .i_id_src1      (bus.id_src1),
    .i_id_src2      (bus.id_src2),
    .i_id_use_src1  (bus.id_use_src1),
    .i_id_two_src   (bus.id_two_src),
    .i_exe_dest     (bus.exe_dest),
    .i_exe_wb_en    (bus.exe_wb_en),
    .i_exe_mem_r_en (bus.exe_mem_r_en),
    .i_mem_dest     (bus.mem_dest),
    .i_mem_wb_en    (bus.mem_wb_en),
    .o_hz           (w_hz)
  );

  // Memory freeze: either already waiting or a fresh request the memory cannot finish now.
  assign w_hold = ((r_state == ST_WAIT) || bus.mem_req) && !bus.mem_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = ST_RUN;
    w_stall_inc    = 1'b0;
    w_flush_inc    = 1'b0;
    w_pc_ld        = 1'b0;
    w_if_id_ld     = 1'b0;
    w_if_id_flush  = 1'b0;
    w_id_exe_ld    = 1'b0;
    w_id_exe_flush = 1'b0;
    w_exe_mem_ld   = 1'b0;
    w_mem_wb_ld    = 1'b0;
    if (w_hold) begin
      w_state_nxt = ST_WAIT;
    end
    if (!rst) begin
      if (w_hold) begin
        w_stall_inc = 1'b1;
      end else if (bus.branch_taken) begin
        w_flush_inc    = 1'b1;
        w_pc_ld        = 1'b1;
        w_if_id_ld     = 1'b1;
        w_if_id_flush  = 1'b1;
        w_id_exe_ld    = 1'b1;
        w_id_exe_flush = 1'b1;
        w_exe_mem_ld   = 1'b1;
        w_mem_wb_ld    = 1'b1;
      end else if (w_hz) begin
        w_stall_inc    = 1'b1;
        w_id_exe_ld    = 1'b1;
        w_id_exe_flush = 1'b1;
        w_exe_mem_ld   = 1'b1;
        w_mem_wb_ld    = 1'b1;
      end else begin
        w_pc_ld      = 1'b1;
        w_if_id_ld   = 1'b1;
        w_id_exe_ld  = 1'b1;
        w_exe_mem_ld = 1'b1;
        w_mem_wb_ld  = 1'b1;
      end
    end
  end

  // The entering cycle already counts as a wait cycle.
  always_comb begin
    w_wait_nxt = r_wait_cnt;
    if (!w_hold) begin
      w_wait_nxt = '0;
    end else if (r_wait_cnt != WAIT_MAX) begin
      w_wait_nxt = r_wait_cnt + WAIT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wait_cnt    <= '0;
      r_stall_cnt   <= '0;
      r_flush_cnt   <= '0;
      r_mem_timeout <= 1'b0;
    end else begin
      r_wait_cnt <= w_wait_nxt;
      if (bus.cnt_clr) begin
        r_stall_cnt   <= '0;
        r_flush_cnt   <= '0;
        r_mem_timeout <= 1'b0;
      end else begin
        if (w_stall_inc && (r_stall_cnt != CNT_MAX)) begin
          r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
        if (w_flush_inc && (r_flush_cnt != CNT_MAX)) begin
          r_flush_cnt <= r_flush_cnt + CNT_W'(1);
        end
        if (w_hold && (w_wait_nxt == WAIT_MAX)) begin
          r_mem_timeout <= 1'b1;
        end
      end
    end
  end

  assign bus.pc_ld        = w_pc_ld;
  assign bus.if_id_ld     = w_if_id_ld;
  assign bus.if_id_flush  = w_if_id_flush;
  assign bus.id_exe_ld    = w_id_exe_ld;
  assign bus.id_exe_flush = w_id_exe_flush;
  assign bus.exe_mem_ld   = w_exe_mem_ld;
  assign bus.mem_wb_ld    = w_mem_wb_ld;
  assign bus.stall_cnt    = r_stall_cnt;
  assign bus.flush_cnt    = r_flush_cnt;
  assign bus.mem_timeout  = r_mem_timeout;

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Pipeline control block that drives the load-enable and flush inputs of every pipeline register: PC, IF/ID, ID/EXE, EXE/MEM and MEM/WB.
It detects RAW hazards between the instruction in ID and the instructions in EXE/MEM, and inserts a bubble into ID/EXE when one is found.
It squashes IF/ID and ID/EXE when EXE resolves a taken branch, and freezes the whole pipeline while the data memory is busy.
It also keeps stall and flush performance counters, plus a sticky memory-timeout flag.

Parameters:
FWD_EN, 1, 1 = forwarding present, so only load-use stalls; 0 = any RAW hit against EXE or MEM stalls.
CNT_W, 32, width of the performance counters.
TMO_CYC, 255, number of consecutive memory-wait cycles before mem_timeout sets.

Ports:
clk  in  1  clock
rst  in  1  reset
id_src1  in  4  Rn index of the ID instruction
id_src2  in  4  Rm/Rd index of the ID instruction
id_use_src1  in  1  ID instruction reads src1
id_two_src  in  1  ID instruction reads src2
exe_dest  in  4  destination register in EXE
exe_wb_en  in  1  EXE instruction writes back
exe_mem_r_en  in  1  EXE instruction is a load
mem_dest  in  4  destination register in MEM
mem_wb_en  in  1  MEM instruction writes back
branch_taken  in  1  EXE resolved a taken branch
mem_req  in  1  MEM stage access pending
mem_ready  in  1  memory completes the access this cycle
cnt_clr  in  1  synchronous clear of both counters and mem_timeout
pc_ld  out  1  PC load enable
if_id_ld  out  1  IF/ID load enable
if_id_flush  out  1  IF/ID flush
id_exe_ld  out  1  ID/EXE load enable
id_exe_flush  out  1  ID/EXE flush (bubble insertion)
exe_mem_ld  out  1  EXE/MEM load enable
mem_wb_ld  out  1  MEM/WB load enable
stall_cnt  out  CNT_W  stall cycles, saturating
flush_cnt  out  CNT_W  branch flushes, saturating
mem_timeout  out  1  sticky: a memory wait exceeded TMO_CYC

Behaviour:
- Reset and clock: reset rst, asynchronous, active-high; clock clk.
- While rst is high:
  - state = RUN, wait_cnt = 0, stall_cnt = 0, flush_cnt = 0, mem_timeout = 0.
  - All ld and flush outputs = 0.
- Control outputs are combinational from state and current inputs, so they act in the same cycle. Counters, state and mem_timeout are registered.
- Hazard detect (hz):
  - hit1 = id_use_src1 & (id_src1 == D).
  - hit2 = id_two_src & (id_src2 == D).
  - FWD_EN = 1: hz = exe_wb_en & exe_mem_r_en & (hit1 | hit2), with D = exe_dest.
  - FWD_EN = 0: hz = (exe_wb_en & hit vs exe_dest) | (mem_wb_en & hit vs mem_dest).
- Freeze condition: frz = (state == WAIT) | (mem_req & ~mem_ready).
- Output priority, highest first:
  1. frz & ~mem_ready: all ld = 0, all flush = 0. branch_taken and hz are ignored, since upstream state is held.
  2. branch_taken: all ld = 1, if_id_flush = 1, id_exe_flush = 1.
  3. hz: pc_ld = 0, if_id_ld = 0, id_exe_flush = 1; id_exe_ld, exe_mem_ld and mem_wb_ld = 1.
  4. Otherwise: all ld = 1, flushes = 0.
- FSM:
  - RUN -> WAIT when mem_req & ~mem_ready.
  - WAIT -> RUN on the cycle mem_ready = 1. That cycle evaluates priorities 2-4 normally, so the pipeline advances.
  - WAIT with ~mem_ready: stay in WAIT.
- wait_cnt:
  - Increments each cycle in WAIT (also on the entering cycle) and saturates at TMO_CYC.
  - Cleared to 0 in RUN.
  - mem_timeout sets when wait_cnt == TMO_CYC while still waiting.
  - mem_timeout stays set until cnt_clr or rst; the freeze continues regardless.
- stall_cnt: +1 on each cycle in which priority 1 or 3 is active.
- flush_cnt: +1 on each cycle in which priority 2 is active.
- Both counters saturate at 2^CNT_W - 1. cnt_clr has priority over an increment in the same cycle.
- Reset mid-wait: the pipeline returns to RUN immediately, and all counters and flags clear.

Decomposition:
- Shared package: state encoding (RUN = 1'b0, WAIT = 1'b1) and the 4-bit register-index width constant.
- Sub-module hazard_detect: the combinational hz logic, parameterised by FWD_EN.
- All other logic stays in pipe_hazard_ctrl.

Test Plan:
- Reset: assert rst mid-stream with mem_req = 1, mem_ready = 0 -> all ld = 0, counters = 0, state RUN; after release with no hazards, all ld = 1.
- Load-use, FWD_EN = 1: exe_dest = 3, exe_wb_en = 1, exe_mem_r_en = 1, id_src1 = 3, id_use_src1 = 1 -> pc_ld = 0, if_id_ld = 0, id_exe_flush = 1 for one cycle; stall_cnt = 1. Repeat with exe_mem_r_en = 0 -> no stall.
- Branch plus hazard in the same cycle: branch_taken = 1 with the load-use condition above -> if_id_flush = 1, id_exe_flush = 1, pc_ld = 1; flush_cnt = 1, stall_cnt unchanged.
- Memory wait: mem_req = 1 with mem_ready low for 3 cycles, then high:
  - Waiting cycles: all ld = 0 for 3 cycles, branch_taken = 1 is ignored, stall_cnt = 3.
  - Release cycle: branch flush occurs and flush_cnt = 1.
- Timeout: TMO_CYC = 4, mem_ready held low for 6 cycles -> mem_timeout = 1 after the 4th wait cycle and stays 1 after release; cnt_clr clears it.
- FWD_EN = 0: mem_dest = 7, mem_wb_en = 1, id_src2 = 7, id_two_src = 1 -> stall for one cycle; the same case with FWD_EN = 1 -> no stall.
